mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Two-requester arbiter for the single-port unified instruction/data memory.
//  Requesters: the CPU core (fetch and load/store) and a program-loader/debug port.
//  Grants one transaction at a time with a req/ack handshake.
//  Drives the memory's Address/Write_data/MemRead/MemWrite and returns registered read data.
// PARAMETERS
//  ADDR_W          32      address width, byte address; bits [1:0] ignored (word access)
//  DATA_W          32      data width
//  LDR_ADDR_LIMIT  32'h400 loader accesses with addr >= limit are rejected (256 words x 4 B)
// PORTS
//  clk        in   1       clock; all state updates on posedge
//  reset      in   1       asynchronous, active-high
//  cpu_req    in   1       CPU transaction request; hold with cpu_we/addr/wdata stable until cpu_ack
//  cpu_we     in   1       1 = write, 0 = read
//  cpu_addr   in   ADDR_W  CPU byte address
//  cpu_wdata  in   DATA_W  CPU write data
//  cpu_ack    out  1       one-cycle completion pulse
//  cpu_rdata  out  DATA_W  read data; valid while cpu_ack=1, held until next CPU read completes
//  ldr_req    in   1       loader request (same rules as cpu_req)
//  ldr_we     in   1       loader write enable
//  ldr_addr   in   ADDR_W  loader byte address
//  ldr_wdata  in   DATA_W  loader write data
//  ldr_ack    out  1       one-cycle completion pulse
//  ldr_err    out  1       valid with ldr_ack: 1 = address out of window, no memory access made
//  ldr_rdata  out  DATA_W  loader read data; valid while ldr_ack=1
//  mem_addr   out  ADDR_W  to memory Address
//  mem_wdata  out  DATA_W  to memory Write_data
//  mem_read   out  1       to memory MemRead
//  mem_write  out  1       to memory MemWrite
//  mem_rdata  in   DATA_W  from memory Mem_data (combinational read)
// BEHAVIOUR
//  - Reset values: all acks = 0; ldr_err = 0; rdata outputs = 0; mem_read = mem_write = 0;
//    mem_addr = mem_wdata = 0; FSM = IDLE; last_grant = LDR.
//  - FSM states IDLE -> ACCESS -> RESP -> IDLE.
//    IDLE: sample reqs. If any req is high, latch winner id, we, addr and wdata; go to ACCESS.
//    ACCESS (1 cycle): drive mem_addr/mem_wdata from latched values.
//      Write: mem_write = 1 (memory commits at the closing edge).
//      Read: mem_read = 1; mem_rdata is captured into the winner's rdata register at the closing edge.
//      Go to RESP.
//    RESP (1 cycle): winner's ack = 1; mem_read = mem_write = 0; both reqs ignored; go to IDLE.
//  - Latency: req high at edge N (FSM in IDLE) -> ack high in cycle N+2.
//    Throughput is one transaction per 3 cycles.
//  - A req still high in the IDLE cycle after RESP starts a new transaction; a requester that
//    wants exactly one access drops req in the cycle after ack.
//  - mem_read and mem_write are never both 1. Neither is 1 outside ACCESS.
//    mem_addr/mem_wdata hold their last values outside ACCESS.
//  - Loader window check is done in IDLE on ldr_addr.
//    If ldr_addr >= LDR_ADDR_LIMIT: ACCESS is skipped with no mem strobes, and RESP gives
//    ldr_ack = 1, ldr_err = 1, ldr_rdata = 0.
//    CPU accesses are never range-checked.
//  - Tie (both reqs high in IDLE): resolved per CONFIGURATION. last_grant updates to the winner on
//    every IDLE->ACCESS and on every rejected loader transaction.
//  - Request inputs that change while not in IDLE are ignored; latched values are used.
//  - Reset asserted mid-transaction: immediate return to reset values. Any in-flight write strobe
//    is dropped, no ack is issued, and requesters must re-issue.
// CONFIGURATION
//  MEM_ARB_ROUND_ROBIN_EN defined: on a tie, grant the requester that is not last_grant.
//    With reset value LDR, the CPU wins the first tie.
//  MEM_ARB_ROUND_ROBIN_EN undefined: fixed priority; the CPU always wins ties. last_grant is still
//    maintained but unused.
// TESTING
//  1. CPU read: preload word 5 = 32'h0C000005; cpu_req=1, we=0, addr=32'h14 ->
//     mem_read=1 for 1 cycle, cpu_ack at N+2, cpu_rdata=32'h0C000005.
//  2. Loader write then CPU read: ldr write addr=32'h80, data=32'hDEADBEEF -> mem_write pulse of
//     1 cycle with mem_addr=32'h80, ldr_ack, ldr_err=0; then CPU read 32'h80 returns 32'hDEADBEEF.
//  3. Tie, both reqs held high for 4 transactions:
//     with MEM_ARB_ROUND_ROBIN_EN, grant order is CPU, LDR, CPU, LDR;
//     without it, grant order is CPU, CPU, CPU, CPU and ldr_ack never asserts.
//  4. Loader out of window: ldr write addr=32'h400 -> no mem_write ever; ldr_ack=1, ldr_err=1 at N+2;
//     memory contents unchanged.
//  5. Reset during ACCESS of a CPU write to 32'h20: reset asserted mid-cycle -> mem_write=0
//     immediately, no cpu_ack, FSM in IDLE.
//  6. Back-to-back: cpu_req held high for 3 reads -> acks at cycles N+2, N+5, N+8; never two acks
//     in the same cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - CPU/loader arbiter for the unified single-port memory
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; the default gives the CPU fixed priority.
module mem_port_arbiter #(
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter logic [ADDR_W-1:0] LDR_ADDR_LIMIT = 'h400
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_ack,
  output logic              ldr_err,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit ROUND_ROBIN = 1'b1;
`else
  localparam bit ROUND_ROBIN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state;
  logic              win_ldr;
  logic              last_ldr;
  logic              lat_we;
  logic              lat_rej;
  logic              pick_ldr;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_rej;

  // On a tie, round-robin favours whoever did not win last; fixed mode always picks the CPU.
  always_comb begin
    pick_ldr = 1'b0;
    if (ldr_req && !cpu_req)
      pick_ldr = 1'b1;
    else if (ldr_req && cpu_req)
      pick_ldr = ROUND_ROBIN ? !last_ldr : 1'b0;
  end

  assign sel_we    = pick_ldr ? ldr_we    : cpu_we;
  assign sel_addr  = pick_ldr ? ldr_addr  : cpu_addr;
  assign sel_wdata = pick_ldr ? ldr_wdata : cpu_wdata;
  assign sel_rej   = pick_ldr && (ldr_addr >= LDR_ADDR_LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      win_ldr   <= 1'b0;
      last_ldr  <= 1'b1;
      lat_we    <= 1'b0;
      lat_rej   <= 1'b0;
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
      ldr_ack   <= 1'b0;
      ldr_err   <= 1'b0;
      ldr_rdata <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req || ldr_req) begin
            win_ldr  <= pick_ldr;
            last_ldr <= pick_ldr;
            lat_we   <= sel_we;
            lat_rej  <= sel_rej;
            state    <= ACCESS;
            // A rejected loader access still spends the ACCESS cycle so ack latency is uniform.
            if (!sel_rej) begin
              mem_addr  <= sel_addr;
              mem_wdata <= sel_wdata;
              mem_read  <= !sel_we;
              mem_write <= sel_we;
            end
          end
        end
        ACCESS: begin
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          state     <= RESP;
          if (win_ldr) begin
            ldr_ack <= 1'b1;
            ldr_err <= lat_rej;
            if (lat_rej)
              ldr_rdata <= '0;
            else if (!lat_we)
              ldr_rdata <= mem_rdata;
          end else begin
            cpu_ack <= 1'b1;
            if (!lat_we)
              cpu_rdata <= mem_rdata;
          end
        end
        RESP: begin
          cpu_ack <= 1'b0;
          ldr_ack <= 1'b0;
          ldr_err <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter against a transaction-level model
module tb_mem_port_arbiter;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic        cpu_ack;
  logic [31:0] cpu_rdata;
  logic        ldr_req = 1'b0, ldr_we = 1'b0;
  logic [31:0] ldr_addr = '0, ldr_wdata = '0;
  logic        ldr_ack, ldr_err;
  logic [31:0] ldr_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;

  logic [31:0] ram [0:255];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_idx = '0;
  logic [31:0] pre_data = '0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_ack(ldr_ack), .ldr_err(ldr_err), .ldr_rdata(ldr_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata)
  );

  // Memory: combinational read, write committed at the clock edge.
  assign mem_rdata = ram[mem_addr[9:2]];
  always @(posedge clk) begin
    if (mem_write) ram[mem_addr[9:2]] <= mem_wdata;
    else if (pre_we) ram[pre_idx] <= pre_data;
  end

  int total = 0, bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: transaction schedule (grant, access, response) plus its own memory image.
  int          ph = 0;
  bit          win = 1'b0, last_g = 1'b1, m_we = 1'b0, m_err = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0, exp_cpu_rd = '0;
  logic [31:0] ref_mem [0:255];
  int          cyc = 0, wr_pulses = 0;
  bit          last_err = 1'b0;
  int          ack_cyc[$];
  bit          dut_order[$];

  task automatic model_edge();
    if (ph == 0) begin
      if (cpu_req || ldr_req) begin
        if (cpu_req && ldr_req) win = RR ? !last_g : 1'b0;
        else win = ldr_req;
        last_g  = win;
        m_we    = win ? ldr_we : cpu_we;
        m_addr  = win ? ldr_addr : cpu_addr;
        m_wdata = win ? ldr_wdata : cpu_wdata;
        m_err   = win && (m_addr >= 32'h400);
        if (m_err) m_rdata = '0;
        else if (m_we) ref_mem[m_addr[9:2]] = m_wdata;
        else m_rdata = ref_mem[m_addr[9:2]];
        ph = 1;
      end
    end else if (ph == 1) ph = 2;
    else ph = 0;
  endtask

  task automatic compare();
    bit acc, rsp;
    acc = (ph == 1);
    rsp = (ph == 2);
    if (rsp && !win && !m_we) exp_cpu_rd = m_rdata;
    check("cpu_ack", 32'(cpu_ack), 32'(rsp && !win));
    check("ldr_ack", 32'(ldr_ack), 32'(rsp && win));
    check("ldr_err", 32'(ldr_err), 32'(rsp && win && m_err));
    check("mem_read", 32'(mem_read), 32'(acc && !m_we && !m_err));
    check("mem_write", 32'(mem_write), 32'(acc && m_we && !m_err));
    check("cpu_rdata", cpu_rdata, exp_cpu_rd);
    if (acc && !m_err) begin
      check("mem_addr", mem_addr, m_addr);
      if (m_we) check("mem_wdata", mem_wdata, m_wdata);
    end
    if (rsp && win && (m_err || !m_we)) check("ldr_rdata", ldr_rdata, m_rdata);
    if (mem_write) wr_pulses++;
    if (ldr_ack) last_err = ldr_err;
    if (cpu_ack) begin dut_order.push_back(1'b0); ack_cyc.push_back(cyc); end
    if (ldr_ack) dut_order.push_back(1'b1);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    compare();
  endtask

  task automatic drain(input int max);
    bit done = 1'b0;
    for (int i = 0; i < max && !done; i++) begin
      step();
      if (cpu_ack) cpu_req = 1'b0;
      if (ldr_ack) ldr_req = 1'b0;
      if (!cpu_req && !ldr_req && ph == 0) done = 1'b1;
    end
    if (!done) check("drain_timeout", 32'd1, 32'd0);
  endtask

  task automatic reset_dut();
    cpu_req = 1'b0;
    ldr_req = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_acks", {30'b0, cpu_ack, ldr_ack}, 32'd0);
    check("rst_err", 32'(ldr_err), 32'd0);
    check("rst_strobes", {30'b0, mem_read, mem_write}, 32'd0);
    check("rst_cpu_rdata", cpu_rdata, 32'd0);
    check("rst_ldr_rdata", ldr_rdata, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    reset = 1'b0;
    ph = 0;
    last_g = 1'b1;
    exp_cpu_rd = '0;
  endtask

  initial begin
    int start, n0, a0, w0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      pre_we   = 1'b1;
      pre_idx  = 8'(i);
      pre_data = 32'h0C000000 | 32'(i);
      ref_mem[i] = pre_data;
    end
    @(negedge clk);
    pre_we = 1'b0;
    reset_dut();

    // CPU read of preloaded word 5
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h14;
    start = cyc;
    drain(10);
    check("t1_rdata", cpu_rdata, 32'h0C000005);
    check("t1_latency", 32'(ack_cyc[$] - start), 32'd2);

    // Loader write, then CPU reads it back
    w0 = wr_pulses;
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 32'h80; ldr_wdata = 32'hDEADBEEF;
    drain(10);
    check("t2_wr_pulses", 32'(wr_pulses - w0), 32'd1);
    check("t2_err", 32'(last_err), 32'd0);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h80;
    drain(10);
    check("t2_rdata", cpu_rdata, 32'hDEADBEEF);

    // Tie with both requests held for four transactions
    reset_dut();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 32'h20;
    n0 = dut_order.size();
    for (int i = 0; i < 30 && dut_order.size() < n0 + 4; i++) step();
    cpu_req = 1'b0;
    ldr_req = 1'b0;
    drain(6);
    check("t3_count", 32'(dut_order.size() - n0), 32'd4);
    for (int k = 0; k < 4; k++)
      if (n0 + k < dut_order.size())
        check($sformatf("t3_grant%0d", k), 32'(dut_order[n0 + k]), 32'(RR ? (k % 2) : 0));

    // Loader write outside the window
    w0 = wr_pulses;
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 32'h400; ldr_wdata = 32'h12345678;
    drain(10);
    check("t4_wr_pulses", 32'(wr_pulses - w0), 32'd0);
    check("t4_err", 32'(last_err), 32'd1);
    check("t4_mem0", ram[0], 32'h0C000000);

    // Reset while a CPU write is in its ACCESS cycle
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'hA5A5A5A5;
    @(posedge clk);
    #2;
    check("t5_wr_active", 32'(mem_write), 32'd1);
    reset = 1'b1;
    #1;
    check("t5_wr_dropped", 32'(mem_write), 32'd0);
    cpu_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_no_ack", 32'(cpu_ack), 32'd0);
    end
    reset = 1'b0;
    ph = 0; last_g = 1'b1; exp_cpu_rd = '0;
    check("t5_mem", ram[8], 32'h0C000008);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20;
    start = cyc;
    drain(10);
    check("t5_recover_lat", 32'(ack_cyc[$] - start), 32'd2);
    check("t5_recover_rd", cpu_rdata, 32'h0C000008);

    // Back-to-back CPU reads with req held
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
    a0 = ack_cyc.size();
    start = cyc;
    for (int i = 0; i < 20 && ack_cyc.size() < a0 + 3; i++) step();
    cpu_req = 1'b0;
    drain(6);
    check("t6_count", 32'(ack_cyc.size() - a0), 32'd3);
    if (ack_cyc.size() >= a0 + 3) begin
      check("t6_first", 32'(ack_cyc[a0] - start), 32'd2);
      check("t6_gap1", 32'(ack_cyc[a0 + 1] - ack_cyc[a0]), 32'd3);
      check("t6_gap2", 32'(ack_cyc[a0 + 2] - ack_cyc[a0 + 1]), 32'd3);
    end

    // Random traffic from both requesters
    for (int i = 0; i < 2000; i++) begin
      step();
      if (cpu_ack) cpu_req = 1'b0;
      else if (!cpu_req && $urandom_range(3) == 0) begin
        cpu_req = 1'b1; cpu_we = 1'($urandom_range(1));
        cpu_addr = $urandom_range(32'h3FF); cpu_wdata = $urandom;
      end
      if (ldr_ack) ldr_req = 1'b0;
      else if (!ldr_req && $urandom_range(3) == 0) begin
        ldr_req = 1'b1; ldr_we = 1'($urandom_range(1));
        ldr_addr = $urandom_range(32'h7FF); ldr_wdata = $urandom;
      end
    end
    drain(20);
    for (int i = 0; i < 256; i++) check($sformatf("ram%0d", i), ram[i], ref_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
